// File: rtl/bn_pkg.sv
// rtl/bn_pkg.sv - shared FP16 constants and FSM state type for the batch-norm output path
//
// Purpose:
//   Common definitions imported by the batch-norm output serializer and its
//   per-lane ReLU helper.
// Contents:
//   FP16_W      width of one FP16 lane
//   FP16_SIGN   index of the FP16 sign bit
//   FP16_ZERO   canonical +0.0 encoding
//   bn_state_e  serializer state: EMPTY (no vector held) / LOADED (vector held)
//   min1_clog2  clog2 with a floor of one bit, for counter sizing

package bn_pkg;

  localparam int FP16_W    = 16;
  localparam int FP16_SIGN = 15;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } bn_state_e;

  // A counter over a single value still needs a one-bit register.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp16_relu.sv
// rtl/fp16_relu.sv - single-lane bitwise FP16 ReLU
//
// Purpose:
//   Combinational ReLU on one FP16 lane. Any lane with the sign bit set
//   (-0, negative normals/subnormals, -inf, negative-signed NaN) becomes +0.
//   Positive-signed values, including +NaN and +inf, pass untouched. No FP
//   arithmetic is involved; the decision is the sign bit alone.
// Parameters:
//   EN      nonzero enables ReLU; zero makes the block a wire
// Ports:
//   lane_i  in   FP16 lane
//   lane_o  out  FP16 lane after optional ReLU

module fp16_relu
  import bn_pkg::*;
#(
  parameter int EN = 1
) (
  input  logic [FP16_W-1:0] lane_i,
  output logic [FP16_W-1:0] lane_o
);

  generate
    if (EN != 0) begin : g_relu
      assign lane_o = lane_i[FP16_SIGN] ? FP16_ZERO : lane_i;
    end else begin : g_pass
      assign lane_o = lane_i;
    end
  endgenerate

endmodule

// File: rtl/bn_out_serializer.sv
// rtl/bn_out_serializer.sv - wide-to-narrow FP16 vector serializer with ReLU and frame marker
//
// Purpose:
//   Accepts one SIZE-lane FP16 vector per handshake, applies optional ReLU at
//   accept time, and emits the held vector LANES_OUT lanes per beat. The last
//   beat of the last vector in each frame of VECS_PER_FRAME vectors is flagged
//   with out_last. A new vector can be taken in the same cycle the final beat
//   of the current one is consumed, so there is no bubble between vectors.
// Parameters:
//   SIZE            FP16 lanes per input vector
//   LANES_OUT       FP16 lanes per output beat (must divide SIZE)
//   RELU_EN         nonzero applies ReLU per lane
//   VECS_PER_FRAME  input vectors per frame (>= 1)
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   in_valid   in   upstream vector valid
//   in_ready   out  vector can be accepted this cycle
//   in_data    in   [0:16*SIZE-1], lane k at [16k +: 16] (lane 0 in MSBs)
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts the beat
//   out_data   out  [0:16*LANES_OUT-1], same lane ordering as in_data
//   out_last   out  last beat of the last vector of a frame
//   busy       out  vector held, or frame partially emitted

module bn_out_serializer
  import bn_pkg::*;
#(
  parameter int SIZE           = 4,
  parameter int LANES_OUT      = 1,
  parameter int RELU_EN        = 1,
  parameter int VECS_PER_FRAME = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [0:FP16_W*SIZE-1]    in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [0:FP16_W*LANES_OUT-1] out_data,
  output logic                      out_last,
  output logic                      busy
);

  localparam int BEATS  = SIZE / LANES_OUT;
  localparam int BEAT_W = min1_clog2(BEATS);
  localparam int VEC_W  = min1_clog2(VECS_PER_FRAME);
  localparam int IN_W   = FP16_W * SIZE;
  localparam int OUT_W  = FP16_W * LANES_OUT;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(VECS_PER_FRAME - 1);

  generate
    if (LANES_OUT < 1 || (SIZE % LANES_OUT) != 0) begin : g_bad_lanes
      $error("bn_out_serializer: SIZE must be a multiple of LANES_OUT");
    end
    if (VECS_PER_FRAME < 1) begin : g_bad_frame
      $error("bn_out_serializer: VECS_PER_FRAME must be at least 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bn_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q,  beat_d;
  logic [VEC_W-1:0]  vcnt_q,  vcnt_d;
  logic [0:IN_W-1]   vec_q,   vec_d;

  // ---------------------------------------------------------------------------
  // Input-path ReLU, one lane per instance
  // ---------------------------------------------------------------------------
  logic [0:IN_W-1] relu_data;

  generate
    for (genvar k = 0; k < SIZE; k++) begin : g_lane
      logic [FP16_W-1:0] lane_in;
      logic [FP16_W-1:0] lane_out;

      assign lane_in = in_data[k*FP16_W +: FP16_W];

      fp16_relu #(
        .EN (RELU_EN)
      ) u_relu (
        .lane_i (lane_in),
        .lane_o (lane_out)
      );

      assign relu_data[k*FP16_W +: FP16_W] = lane_out;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic last_beat;
  logic in_fire;
  logic out_fire;

  assign last_beat = (beat_q == LAST_BEAT);
  assign out_valid = (state_q == LOADED);

  // The register frees up in the very cycle its final beat is consumed, so
  // in_ready looks at out_ready combinationally. Nothing here depends on
  // in_valid, which keeps upstream free of a combinational loop through us.
  assign in_ready = (state_q == EMPTY) || (last_beat && out_ready);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign out_last = out_valid && last_beat && (vcnt_q == LAST_VEC);
  assign busy     = (state_q == LOADED) || (vcnt_q != '0);

  // ---------------------------------------------------------------------------
  // Beat select. Held registers drive this mux, so data is stable during a
  // stall without any extra output register.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_data = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) begin
        out_data = vec_q[b*OUT_W +: OUT_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    vcnt_d  = vcnt_q;
    vec_d   = vec_q;

    if (out_fire) begin
      if (last_beat) begin
        beat_d  = '0;
        vcnt_d  = (vcnt_q == LAST_VEC) ? '0 : vcnt_q + VEC_W'(1);
        state_d = EMPTY;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end

    // An accept overrides the drop to EMPTY above: this is the back-to-back
    // case where the final beat leaves and the next vector lands together.
    if (in_fire) begin
      vec_d   = relu_data;
      state_d = LOADED;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      beat_q  <= '0;
      vcnt_q  <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      vcnt_q  <= vcnt_d;
      vec_q   <= vec_d;
    end
  end

endmodule

// File: tb/tb_bn_out_serializer.sv
// tb/tb_bn_out_serializer.sv - directed self-checking bench for bn_out_serializer

module tb_bn_out_serializer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [0:63] in_data;

  // u_a: ReLU on, 1 lane/beat, 8 vectors/frame
  logic        a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [0:15] a_out_data;
  // u_b: ReLU off, 1 lane/beat, 8 vectors/frame
  logic        b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [0:15] b_out_data;
  // u_c: ReLU off, 2 lanes/beat, 2 vectors/frame
  logic        c_in_ready, c_out_valid, c_out_last, c_busy;
  logic [0:31] c_out_data;

  int checks;
  int errors;

  bn_out_serializer #(.SIZE(4), .LANES_OUT(1), .RELU_EN(1), .VECS_PER_FRAME(8)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy)
  );

  bn_out_serializer #(.SIZE(4), .LANES_OUT(1), .RELU_EN(0), .VECS_PER_FRAME(8)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy)
  );

  bn_out_serializer #(.SIZE(4), .LANES_OUT(2), .RELU_EN(0), .VECS_PER_FRAME(2)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_last(c_out_last), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] V1 = 64'h3C00_BC00_8000_7E00;
  localparam logic [63:0] V2 = 64'h1111_2222_3333_4444;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h exp 0000", a_out_data); end
    checks++; if (a_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", a_out_last); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
    do_reset();
  endtask

  task automatic test_relu();
    logic [15:0] exp_d [4];
    exp_d = '{16'h3C00, 16'h0000, 16'h0000, 16'h7E00};
    do_reset();
    in_valid = 1'b1; in_data = V1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL relu_in_ready_empty got %b exp 1", a_in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL relu_valid beat %0d got %b exp 1", k, a_out_valid); end
      checks++; if (a_out_data !== exp_d[k]) begin errors++; $display("FAIL relu_data beat %0d got %h exp %h", k, a_out_data, exp_d[k]); end
      tick();
    end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL relu_valid_after got %b exp 0", a_out_valid); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL relu_busy_midframe got %b exp 1", a_busy); end
  endtask

  task automatic test_pass_backpressure();
    logic [15:0] exp_d [4];
    logic        exp_r [4];
    exp_d = '{16'h3C00, 16'hBC00, 16'h8000, 16'h7E00};
    exp_r = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    in_valid = 1'b1; in_data = V1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (b_out_data !== exp_d[k]) begin errors++; $display("FAIL pass_data beat %0d got %h exp %h", k, b_out_data, exp_d[k]); end
      checks++; if (b_in_ready !== exp_r[k]) begin errors++; $display("FAIL pass_in_ready beat %0d got %b exp %b", k, b_in_ready, exp_r[k]); end
      checks++; if (b_out_last !== 1'b0) begin errors++; $display("FAIL pass_last beat %0d got %b exp 0", k, b_out_last); end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_d [4];
    exp_d = '{16'h3C00, 16'hBC00, 16'h8000, 16'h7E00};
    do_reset();
    in_valid = 1'b1; in_data = V1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b_out_data !== 16'h3C00) begin errors++; $display("FAIL stall_beat0 got %h exp 3C00", b_out_data); end
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b exp 1", s, b_out_valid); end
      checks++; if (b_out_data !== 16'hBC00) begin errors++; $display("FAIL stall_data cyc %0d got %h exp BC00", s, b_out_data); end
      checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b exp 0", s, b_in_ready); end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      checks++; if (b_out_data !== exp_d[k]) begin errors++; $display("FAIL stall_resume beat %0d got %h exp %h", k, b_out_data, exp_d[k]); end
      tick();
    end
    @(negedge clk);
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL stall_done_valid got %b exp 0", b_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [8];
    exp_d = '{16'h3C00, 16'hBC00, 16'h8000, 16'h7E00,
              16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_reset();
    in_valid = 1'b1; in_data = V1; out_ready = 1'b1;
    tick();
    in_data = V2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %b exp 1", k, b_out_valid); end
      checks++; if (b_out_data !== exp_d[k]) begin errors++; $display("FAIL b2b_data beat %0d got %h exp %h", k, b_out_data, exp_d[k]); end
      if (k == 3) begin
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_final got %b exp 1", b_in_ready); end
      end
      tick();
      if (k == 3) in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_after got %b exp 0", b_out_valid); end
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_counter got %b exp 1", b_busy); end
  endtask

  task automatic test_frame();
    logic [31:0] exp_d [2];
    logic        exp_l [8];
    exp_d = '{32'h3C00_BC00, 32'h8000_7E00};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    in_valid = 1'b1; in_data = V1; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL frame_valid beat %0d got %b exp 1", k, c_out_valid); end
      checks++; if (c_out_data !== exp_d[k % 2]) begin errors++; $display("FAIL frame_data beat %0d got %h exp %h", k, c_out_data, exp_d[k % 2]); end
      checks++; if (c_out_last !== exp_l[k]) begin errors++; $display("FAIL frame_last beat %0d got %b exp %b", k, c_out_last, exp_l[k]); end
      tick();
      if (k == 5) in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL frame_valid_after got %b exp 0", c_out_valid); end
    checks++; if (c_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_wrapped got %b exp 0", c_busy); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_d [4];
    exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_reset();
    in_valid = 1'b1; in_data = V1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++; if (b_out_data !== 16'h8000) begin errors++; $display("FAIL rmid_beat2 got %h exp 8000", b_out_data); end
    checks++; if (c_busy !== 1'b1) begin errors++; $display("FAIL rmid_c_busy_before got %b exp 1", c_busy); end
    reset = 1'b0;
    #1;
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", b_out_valid); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", b_busy); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", b_in_ready); end
    checks++; if (c_busy !== 1'b0) begin errors++; $display("FAIL rmid_c_busy got %b exp 0", c_busy); end
    #1;
    reset = 1'b1;
    in_valid = 1'b1; in_data = V2;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (b_out_data !== exp_d[k]) begin errors++; $display("FAIL rmid_next beat %0d got %h exp %h", k, b_out_data, exp_d[k]); end
      if (k == 1) begin
        checks++; if (c_out_last !== 1'b0) begin errors++; $display("FAIL rmid_c_last_counter got %b exp 0", c_out_last); end
        checks++; if (c_out_data !== 32'h3333_4444) begin errors++; $display("FAIL rmid_c_data got %h exp 33334444", c_out_data); end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_relu();
    test_pass_backpressure();
    test_stall();
    test_back_to_back();
    test_frame();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
